// File: rtl/pulpemu_pkg.sv
// Shared types and constants for the PULP emulator SPI mode-switch logic.
package pulpemu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CS,
    DRAIN,
    GUARD_PRE,
    SWITCH,
    GUARD_POST
  } spi_mode_state_e;

  localparam logic MODE_ZYNQ = 1'b0;
  localparam logic MODE_FMC  = 1'b1;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulpemu_outstanding_cnt.sv
// Saturating up/down counter of outstanding AXI transactions with a zero flag.
module pulpemu_outstanding_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc/dec cancel; the count sticks at both ends instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulpemu_spi_mode_ctrl.sv
// Sequences the SPI master mode switch between the Zynq AXI bridge and the FMC pads.
// state      | meaning
// IDLE       | mode applied, gate open, watching for a mode mismatch
// WAIT_CS    | waiting for csn to stay high CS_IDLE_CYCLES cycles
// DRAIN      | gate closed, waiting for outstanding AXI bursts to finish
// GUARD_PRE  | gate closed, settling before the flip
// SWITCH     | mode register just flipped
// GUARD_POST | gate closed, settling after the flip; ends with done
module pulpemu_spi_mode_ctrl
  import pulpemu_pkg::*;
#(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned CS_IDLE_CYCLES = 16,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic zynq_clk,
  input  logic zynq_rst,
  input  logic mode_req_i,
  input  logic pulp_spi_csn_i,
  input  logic axi_aw_hs_i,
  input  logic axi_ar_hs_i,
  input  logic axi_b_hs_i,
  input  logic axi_r_last_hs_i,
  output logic mode_fmc_zynqn_o,
  output logic spi_gate_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned IDLE_W = cnt_w(CS_IDLE_CYCLES);
  localparam int unsigned GRD_W  = cnt_w(GUARD_CYCLES);
  localparam int unsigned TMO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(CS_IDLE_CYCLES);
  localparam logic [GRD_W-1:0]  GRD_LD  = GRD_W'(GUARD_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LD  = TMO_W'(TIMEOUT_CYCLES);
  localparam bit                TMO_EN  = (TIMEOUT_CYCLES != 0);

  spi_mode_state_e   r_state;
  logic              r_mode;
  logic              r_gate;
  logic              r_busy;
  logic              r_done;
  logic              r_tmo;
  logic              r_csn_meta;
  logic              r_csn_s;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [GRD_W-1:0]  r_grd_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;

  logic w_wr_zero;
  logic w_rd_zero;
  logic w_req_pend;
  logic w_tmo_hit;
  logic w_abort;

  pulpemu_outstanding_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .i_clk  (zynq_clk),
    .i_rst  (zynq_rst),
    .i_inc  (axi_aw_hs_i),
    .i_dec  (axi_b_hs_i),
    .o_zero (w_wr_zero)
  );

  pulpemu_outstanding_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .i_clk  (zynq_clk),
    .i_rst  (zynq_rst),
    .i_inc  (axi_ar_hs_i),
    .i_dec  (axi_r_last_hs_i),
    .o_zero (w_rd_zero)
  );

  // csn idles high, so the synchronizer resets to 1 to avoid a fake activity edge.
  always_ff @(posedge zynq_clk) begin
    if (zynq_rst) begin
      r_csn_meta <= 1'b1;
      r_csn_s    <= 1'b1;
    end else begin
      r_csn_meta <= pulp_spi_csn_i;
      r_csn_s    <= r_csn_meta;
    end
  end

  assign w_req_pend = (mode_req_i != r_mode);
  assign w_tmo_hit  = TMO_EN && (r_tmo_cnt == TMO_W'(1));
  assign w_abort    = !w_req_pend || w_tmo_hit;

  always_ff @(posedge zynq_clk) begin
    if (zynq_rst) begin
      r_state    <= IDLE;
      r_mode     <= MODE_ZYNQ;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_idle_cnt <= '0;
      r_grd_cnt  <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      if (r_state inside {WAIT_CS, DRAIN, GUARD_PRE}) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
      // Withdrawal wins over timeout, so a dropped request never reports an abort.
      if ((r_state inside {WAIT_CS, DRAIN, GUARD_PRE}) && w_abort) begin
        r_state <= IDLE;
        r_gate  <= 1'b0;
        r_busy  <= 1'b0;
        r_tmo   <= w_req_pend;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_req_pend) begin
              r_state    <= WAIT_CS;
              r_busy     <= 1'b1;
              r_idle_cnt <= '0;
              r_tmo_cnt  <= TMO_LD;
            end
          end
          WAIT_CS: begin
            if (!r_csn_s) begin
              r_idle_cnt <= '0;
            end else if (r_idle_cnt == IDLE_TC) begin
              r_state <= DRAIN;
              r_gate  <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
          DRAIN: begin
            if (w_wr_zero && w_rd_zero) begin
              r_state   <= GUARD_PRE;
              r_grd_cnt <= GRD_LD;
            end
          end
          GUARD_PRE: begin
            if (r_grd_cnt <= GRD_W'(1)) begin
              r_state <= SWITCH;
              r_mode  <= mode_req_i ? MODE_FMC : MODE_ZYNQ;
            end else begin
              r_grd_cnt <= r_grd_cnt - 1'b1;
            end
          end
          SWITCH: begin
            r_state   <= GUARD_POST;
            r_grd_cnt <= GRD_LD;
          end
          GUARD_POST: begin
            if (r_grd_cnt <= GRD_W'(1)) begin
              r_state <= IDLE;
              r_gate  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_grd_cnt <= r_grd_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mode_fmc_zynqn_o = r_mode;
  assign spi_gate_o       = r_gate;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign timeout_o        = r_tmo;

endmodule

// File: tb/tb_pulpemu_spi_mode_ctrl.sv
// Bench for pulpemu_spi_mode_ctrl: timestamp-based reference model, directed scenarios, random traffic.
module tb_pulpemu_spi_mode_ctrl;

  localparam int CS   = 16;
  localparam int GRD  = 4;
  localparam int TMO  = 100;
  localparam int CMAX = 15;

  localparam int M_IDLE  = 0;
  localparam int M_CS    = 1;
  localparam int M_DRAIN = 2;
  localparam int M_PRE   = 3;
  localparam int M_POST  = 4;

  logic zynq_clk = 1'b0;
  logic zynq_rst = 1'b1;
  logic mode_req_i = 1'b0;
  logic pulp_spi_csn_i = 1'b1;
  logic axi_aw_hs_i = 1'b0;
  logic axi_ar_hs_i = 1'b0;
  logic axi_b_hs_i = 1'b0;
  logic axi_r_last_hs_i = 1'b0;
  logic mode_fmc_zynqn_o, spi_gate_o, busy_o, done_o, timeout_o;

  int n_vec = 0;
  int n_err = 0;

  pulpemu_spi_mode_ctrl #(
    .CNT_W(4), .CS_IDLE_CYCLES(CS), .GUARD_CYCLES(GRD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .zynq_clk        (zynq_clk),
    .zynq_rst        (zynq_rst),
    .mode_req_i      (mode_req_i),
    .pulp_spi_csn_i  (pulp_spi_csn_i),
    .axi_aw_hs_i     (axi_aw_hs_i),
    .axi_ar_hs_i     (axi_ar_hs_i),
    .axi_b_hs_i      (axi_b_hs_i),
    .axi_r_last_hs_i (axi_r_last_hs_i),
    .mode_fmc_zynqn_o(mode_fmc_zynqn_o),
    .spi_gate_o      (spi_gate_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .timeout_o       (timeout_o)
  );

  always #5 zynq_clk = ~zynq_clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with absolute deadlines instead of down-counters.
  logic m_mode, m_gate, m_busy, m_done, m_tmo, m_s1, m_s2, m_cs_s;
  int   m_ph, m_wr, m_rd, cyc, t_acc, t_clr, t_pre, t_flip;

  initial begin
    cyc = 0; m_ph = M_IDLE; m_wr = 0; m_rd = 0;
    t_acc = 0; t_clr = 0; t_pre = 0; t_flip = 0;
    m_mode = 1'b0; m_gate = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
    m_s1 = 1'b1; m_s2 = 1'b1; m_cs_s = 1'b1;
  end

  always @(posedge zynq_clk) begin
    if (zynq_rst) begin
      m_mode = 1'b0; m_gate = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_wr = 0; m_rd = 0; m_ph = M_IDLE;
    end else begin
      m_cs_s = m_s2;
      m_done = 1'b0;
      m_tmo  = 1'b0;
      if (m_ph == M_IDLE) begin
        if (mode_req_i != m_mode) begin
          m_ph = M_CS; t_acc = cyc; t_clr = cyc;
        end
      end else if (m_ph == M_POST) begin
        if (cyc == t_flip + GRD + 1) begin
          m_ph = M_IDLE; m_gate = 1'b0; m_done = 1'b1;
        end
      end else if (mode_req_i == m_mode) begin
        m_ph = M_IDLE; m_gate = 1'b0;
      end else if (cyc == t_acc + TMO) begin
        m_ph = M_IDLE; m_gate = 1'b0; m_tmo = 1'b1;
      end else if (m_ph == M_CS) begin
        if (!m_cs_s) t_clr = cyc;
        else if (cyc == t_clr + CS + 1) begin
          m_ph = M_DRAIN; m_gate = 1'b1;
        end
      end else if (m_ph == M_DRAIN) begin
        if (m_wr == 0 && m_rd == 0) begin
          m_ph = M_PRE; t_pre = cyc;
        end
      end else if (cyc == t_pre + GRD) begin
        m_ph = M_POST; t_flip = cyc; m_mode = mode_req_i;
      end
      m_busy = (m_ph != M_IDLE);
      m_s2 = m_s1;
      m_s1 = pulp_spi_csn_i;
      m_wr = m_wr + int'(axi_aw_hs_i) - int'(axi_b_hs_i);
      m_rd = m_rd + int'(axi_ar_hs_i) - int'(axi_r_last_hs_i);
      if (m_wr > CMAX) m_wr = CMAX;
      if (m_wr < 0) m_wr = 0;
      if (m_rd > CMAX) m_rd = CMAX;
      if (m_rd < 0) m_rd = 0;
    end
    cyc++;
  end

  always @(negedge zynq_clk) begin
    chkv("outputs{mode,gate,busy,done,tmo}",
         {3'b0, mode_fmc_zynqn_o, spi_gate_o, busy_o, done_o, timeout_o},
         {3'b0, m_mode, m_gate, m_busy, m_done, m_tmo});
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge zynq_clk);
  endtask

  task automatic do_reset();
    axi_aw_hs_i = 1'b0; axi_ar_hs_i = 1'b0; axi_b_hs_i = 1'b0; axi_r_last_hs_i = 1'b0;
    mode_req_i = 1'b0; pulp_spi_csn_i = 1'b1; zynq_rst = 1'b1;
    step(2);
    zynq_rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_o !== 1'b1; i++) step();
    chk1(name, done_o, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: idle bus, csn high
    do_reset();
    chk1("rst_mode", mode_fmc_zynqn_o, 1'b0);
    chk1("rst_gate", spi_gate_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_tmo", timeout_o, 1'b0);
    mode_req_i = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      step();
      if (c == 1)  chk1("t1_busy_c1", busy_o, 1'b1);
      if (c == 17) chk1("t1_gate_c17", spi_gate_o, 1'b0);
      if (c == 18) chk1("t1_gate_c18", spi_gate_o, 1'b1);
      if (c == 22) chk1("t1_mode_c22", mode_fmc_zynqn_o, 1'b0);
      if (c == 23) chk1("t1_mode_c23", mode_fmc_zynqn_o, 1'b1);
      if (c == 27) chk1("t1_done_c27", done_o, 1'b0);
      if (c == 28) begin
        chk1("t1_done_c28", done_o, 1'b1);
        chk1("t1_gate_c28", spi_gate_o, 1'b0);
        chk1("t1_busy_c28", busy_o, 1'b0);
      end
    end
    step();
    chk1("t1_done_pulse_len", done_o, 1'b0);

    // 2: two writes outstanding, responses at cycles 50 and 60
    do_reset();
    axi_aw_hs_i = 1'b1;
    step(2);
    axi_aw_hs_i = 1'b0;
    mode_req_i = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      step();
      axi_b_hs_i = (c == 49 || c == 59);
      if (c == 10) chkv("t2_wr_cnt_2", {4'b0, dut.u_wr_cnt.r_cnt}, 8'd2);
      if (c == 55) chkv("t2_wr_cnt_1", {4'b0, dut.u_wr_cnt.r_cnt}, 8'd1);
      if (c == 49) chk1("t2_gate_drain", spi_gate_o, 1'b1);
      if (c == 60) chk1("t2_mode_c60", mode_fmc_zynqn_o, 1'b0);
      if (c == 64) chk1("t2_mode_c64", mode_fmc_zynqn_o, 1'b0);
      if (c == 65) chk1("t2_mode_c65", mode_fmc_zynqn_o, 1'b1);
    end
    wait_done("t2_done", 20);

    // 3: csn drops every 10 cycles, last drop at cycle 50
    do_reset();
    mode_req_i = 1'b1;
    for (int c = 1; c <= 69; c++) begin
      step();
      pulp_spi_csn_i = !((c % 10 == 9) && (c < 50));
      if (c < 69) chk1("t3_gate_low", spi_gate_o, 1'b0);
      else chk1("t3_gate_c69", spi_gate_o, 1'b1);
    end
    wait_done("t3_done", 30);

    // 4: one read stuck outstanding -> timeout
    do_reset();
    axi_ar_hs_i = 1'b1;
    step();
    axi_ar_hs_i = 1'b0;
    mode_req_i = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      step();
      if (c == 100) begin
        chk1("t4_tmo_c100", timeout_o, 1'b0);
        chk1("t4_busy_c100", busy_o, 1'b1);
      end
      if (c == 101) begin
        chk1("t4_tmo_c101", timeout_o, 1'b1);
        chk1("t4_gate_c101", spi_gate_o, 1'b0);
        chk1("t4_mode_c101", mode_fmc_zynqn_o, 1'b0);
        chk1("t4_busy_c101", busy_o, 1'b0);
      end
      if (c == 102) begin
        chk1("t4_busy_c102", busy_o, 1'b1);
        chk1("t4_tmo_c102", timeout_o, 1'b0);
      end
    end
    axi_r_last_hs_i = 1'b1;
    step();
    axi_r_last_hs_i = 1'b0;
    wait_done("t4_done_after_drain", 60);
    chk1("t4_mode_final", mode_fmc_zynqn_o, 1'b1);

    // 5: request withdrawn in DRAIN; simultaneous aw/b
    do_reset();
    axi_aw_hs_i = 1'b1;
    step();
    axi_aw_hs_i = 1'b0;
    mode_req_i = 1'b1;
    for (int i = 0; i < 40 && spi_gate_o !== 1'b1; i++) step();
    chk1("t5_gate_drain", spi_gate_o, 1'b1);
    mode_req_i = 1'b0;
    step();
    chk1("t5_gate_rel", spi_gate_o, 1'b0);
    chk1("t5_busy_rel", busy_o, 1'b0);
    chk1("t5_no_done", done_o, 1'b0);
    chk1("t5_no_tmo", timeout_o, 1'b0);
    axi_aw_hs_i = 1'b1;
    axi_b_hs_i = 1'b1;
    step();
    axi_aw_hs_i = 1'b0;
    axi_b_hs_i = 1'b0;
    step();
    chkv("t5_wr_same_cycle", {4'b0, dut.u_wr_cnt.r_cnt}, 8'd1);

    // 6: reset during GUARD_POST
    do_reset();
    mode_req_i = 1'b1;
    for (int i = 0; i < 40 && mode_fmc_zynqn_o !== 1'b1; i++) step();
    chk1("t6_mode_set", mode_fmc_zynqn_o, 1'b1);
    step(2);
    mode_req_i = 1'b0;
    zynq_rst = 1'b1;
    step();
    zynq_rst = 1'b0;
    chk1("t6_mode", mode_fmc_zynqn_o, 1'b0);
    chk1("t6_gate", spi_gate_o, 1'b0);
    chk1("t6_busy", busy_o, 1'b0);
    chk1("t6_done", done_o, 1'b0);
    chkv("t6_state", {5'b0, dut.r_state}, {5'b0, pulpemu_pkg::IDLE});

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) mode_req_i = ~mode_req_i;
      pulp_spi_csn_i  = ($urandom_range(0, 39) != 0);
      axi_aw_hs_i     = ($urandom_range(0, 7) == 0);
      axi_ar_hs_i     = ($urandom_range(0, 7) == 0);
      axi_b_hs_i      = ($urandom_range(0, 5) == 0);
      axi_r_last_hs_i = ($urandom_range(0, 5) == 0);
      zynq_rst        = ($urandom_range(0, 1499) == 0);
      step();
    end
    zynq_rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
